// File: rtl/game_master_pkg.sv
// ---------------------------------------------------------------------------
// game_master_pkg
//   Shared constants for the multi-target game master:
//     - default parameter values for the top level
//     - FSM state encodings (3-bit, kept as plain constants so older
//       blocks that compare raw state codes keep working)
//     - popcount8 helper used for scoring simultaneous hits
// ---------------------------------------------------------------------------
package game_master_pkg;

    localparam int DEF_N_TARGETS   = 2;
    localparam int DEF_N_SHOTS     = 3;
    localparam int DEF_SCORE_WIDTH = 8;
    localparam int DEF_SHOT_WIDTH  = 4;

    // Largest supported target count; popcount8 covers this width.
    localparam int MAX_TARGETS = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_START  = 3'd0;
    localparam logic [2:0] ST_AIM    = 3'd1;
    localparam logic [2:0] ST_SHOOT  = 3'd2;
    localparam logic [2:0] ST_RELOAD = 3'd3;
    localparam logic [2:0] ST_END    = 3'd4;

    // Number of set bits in an 8-bit vector (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/game_hit_tracker.sv
// ---------------------------------------------------------------------------
// game_hit_tracker
//   Remembers which targets have been hit in the current game and keeps a
//   saturating cumulative score.
//
//   Ports:
//     clk, reset     clock, asynchronous active-high reset
//     clear          clear hit_mask (score is kept)
//     update_en      accept this cycle's collisions
//     collision      raw torpedo/target overlap flags
//     hit_mask       registered set of targets already hit
//     hit_mask_next  value hit_mask takes at the next edge
//     all_hit        every target is hit once this cycle's hits are merged
//     any_new        at least one collision on a not-yet-hit target
//     score          registered saturating hit count since reset
// ---------------------------------------------------------------------------
module game_hit_tracker
    import game_master_pkg::*;
#(
    parameter int N_TARGETS   = DEF_N_TARGETS,
    parameter int SCORE_WIDTH = DEF_SCORE_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   update_en,
    input  logic [N_TARGETS-1:0]   collision,
    output logic [N_TARGETS-1:0]   hit_mask,
    output logic [N_TARGETS-1:0]   hit_mask_next,
    output logic                   all_hit,
    output logic                   any_new,
    output logic [SCORE_WIDTH-1:0] score
);

    logic [N_TARGETS-1:0]   hit_mask_q;
    logic [N_TARGETS-1:0]   hit_mask_d;
    logic [N_TARGETS-1:0]   newly_hit;
    logic [SCORE_WIDTH-1:0] score_q;
    logic [SCORE_WIDTH-1:0] score_d;
    logic [7:0]             newly_hit_ext;
    logic [3:0]             new_count;
    // Four spare bits so the sum of score and up to 8 hits cannot wrap.
    logic [SCORE_WIDTH+3:0] score_sum;
    logic [SCORE_WIDTH+3:0] score_max;

    // A target that is already hit cannot score again this game.
    generate
        for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_newly
            assign newly_hit[gi] = collision[gi] & ~hit_mask_q[gi];
        end
    endgenerate

    always_comb begin
        newly_hit_ext                = '0;
        newly_hit_ext[N_TARGETS-1:0] = newly_hit;
    end

    assign new_count = popcount8(newly_hit_ext);
    assign score_sum = {4'b0000, score_q} + {{SCORE_WIDTH{1'b0}}, new_count};
    assign score_max = {4'b0000, {SCORE_WIDTH{1'b1}}};

    assign any_new = |newly_hit;
    assign all_hit = &(hit_mask_q | newly_hit);

    always_comb begin
        hit_mask_d = hit_mask_q;
        score_d    = score_q;
        if (clear) begin
            hit_mask_d = '0;
        end else if (update_en) begin
            hit_mask_d = hit_mask_q | newly_hit;
            if (score_sum > score_max) begin
                score_d = {SCORE_WIDTH{1'b1}};
            end else begin
                score_d = score_sum[SCORE_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_mask_q <= '0;
            score_q    <= '0;
        end else begin
            hit_mask_q <= hit_mask_d;
            score_q    <= score_d;
        end
    end

    assign hit_mask      = hit_mask_q;
    assign hit_mask_next = hit_mask_d;
    assign score         = score_q;

endmodule

// File: rtl/game_master_fsm_multi.sv
// ---------------------------------------------------------------------------
// game_master_fsm_multi
//   Game sequencer for one torpedo against N_TARGETS moving targets with a
//   limited number of launches per game. Every output is registered: the
//   decision taken while the FSM sits in a state appears on the outputs one
//   clock later.
//
//   Ports:
//     clk, reset                     clock, asynchronous active-high reset
//     key                            fire request (level, synchronised)
//     sprite_target_write_xy/dxy     per-target position/velocity load strobes
//     sprite_target_enable_update    per-target motion enable (live targets)
//     sprite_torpedo_write_xy/dxy    torpedo position/velocity load strobes
//     sprite_torpedo_enable_update   torpedo motion enable
//     sprite_target_within_screen    per-target on-screen flags
//     sprite_torpedo_within_screen   torpedo on-screen flag
//     collision                      torpedo/target overlap flags
//     end_of_game_timer_start        one pulse per game when it ends
//     end_of_game_timer_running      end-of-game timer busy
//     game_won                       all targets hit in current/last game
//     hit_mask                       targets hit in this game
//     shots_left                     launches remaining
//     score                          saturating hit count since reset
// ---------------------------------------------------------------------------
module game_master_fsm_multi
    import game_master_pkg::*;
#(
    parameter int N_TARGETS   = DEF_N_TARGETS,
    parameter int N_SHOTS     = DEF_N_SHOTS,
    parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
    parameter int SHOT_WIDTH  = DEF_SHOT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key,
    output logic [N_TARGETS-1:0]   sprite_target_write_xy,
    output logic [N_TARGETS-1:0]   sprite_target_write_dxy,
    output logic [N_TARGETS-1:0]   sprite_target_enable_update,
    output logic                   sprite_torpedo_write_xy,
    output logic                   sprite_torpedo_write_dxy,
    output logic                   sprite_torpedo_enable_update,
    input  logic [N_TARGETS-1:0]   sprite_target_within_screen,
    input  logic                   sprite_torpedo_within_screen,
    input  logic [N_TARGETS-1:0]   collision,
    output logic                   end_of_game_timer_start,
    input  logic                   end_of_game_timer_running,
    output logic                   game_won,
    output logic [N_TARGETS-1:0]   hit_mask,
    output logic [SHOT_WIDTH-1:0]  shots_left,
    output logic [SCORE_WIDTH-1:0] score
);

    localparam logic [SHOT_WIDTH-1:0] SHOTS_INIT = SHOT_WIDTH'(N_SHOTS);

    state_t state_q, state_d;
    // High in the first cycle spent in a state; used for the first-SHOOT
    // velocity strobe and for skipping the timer's start latency in END.
    logic   entered_q, entered_d;

    logic [N_TARGETS-1:0]  tgt_write_xy_q,  tgt_write_xy_d;
    logic [N_TARGETS-1:0]  tgt_write_dxy_q, tgt_write_dxy_d;
    logic [N_TARGETS-1:0]  tgt_enable_q,    tgt_enable_d;
    logic                  torp_write_xy_q,  torp_write_xy_d;
    logic                  torp_write_dxy_q, torp_write_dxy_d;
    logic                  torp_enable_q,    torp_enable_d;
    logic                  timer_start_q,    timer_start_d;
    logic                  game_won_q,       game_won_d;
    logic [SHOT_WIDTH-1:0] shots_left_q,     shots_left_d;

    logic                  trk_clear;
    logic                  trk_update_en;
    logic [N_TARGETS-1:0]  trk_hit_mask;
    logic [N_TARGETS-1:0]  trk_hit_mask_next;
    logic                  trk_all_hit;
    logic                  trk_any_new;

    logic [N_TARGETS-1:0]  live_now;
    logic [N_TARGETS-1:0]  live_next;
    logic                  live_escaped;

    game_hit_tracker #(
        .N_TARGETS   (N_TARGETS),
        .SCORE_WIDTH (SCORE_WIDTH)
    ) u_hit_tracker (
        .clk           (clk),
        .reset         (reset),
        .clear         (trk_clear),
        .update_en     (trk_update_en),
        .collision     (collision),
        .hit_mask      (trk_hit_mask),
        .hit_mask_next (trk_hit_mask_next),
        .all_hit       (trk_all_hit),
        .any_new       (trk_any_new),
        .score         (score)
    );

    assign live_now  = ~trk_hit_mask;
    // Targets hit this cycle stop moving right away.
    assign live_next = ~trk_hit_mask_next;
    // Already-hit targets may drift off screen without ending the game.
    assign live_escaped = |(live_now & ~sprite_target_within_screen);

    always_comb begin
        state_d          = state_q;
        tgt_write_xy_d   = '0;
        tgt_write_dxy_d  = '0;
        tgt_enable_d     = '0;
        torp_write_xy_d  = 1'b0;
        torp_write_dxy_d = 1'b0;
        torp_enable_d    = 1'b0;
        timer_start_d    = 1'b0;
        game_won_d       = game_won_q;
        shots_left_d     = shots_left_q;
        trk_clear        = 1'b0;
        trk_update_en    = 1'b0;

        case (state_q)
            ST_START: begin
                tgt_write_xy_d  = '1;
                tgt_write_dxy_d = '1;
                torp_write_xy_d = 1'b1;
                trk_clear       = 1'b1;
                game_won_d      = 1'b0;
                shots_left_d    = SHOTS_INIT;
                state_d         = ST_AIM;
            end

            ST_AIM: begin
                tgt_enable_d = live_now;
                if (live_escaped) begin
                    timer_start_d = 1'b1;
                    state_d       = ST_END;
                end else if (key && (shots_left_q != '0)) begin
                    shots_left_d = shots_left_q - SHOT_WIDTH'(1);
                    state_d      = ST_SHOOT;
                end
            end

            ST_SHOOT: begin
                trk_update_en    = 1'b1;
                torp_enable_d    = 1'b1;
                tgt_enable_d     = live_next;
                torp_write_dxy_d = entered_q;
                // A hit wins over any simultaneous exit.
                if (trk_any_new) begin
                    if (trk_all_hit) begin
                        game_won_d    = 1'b1;
                        timer_start_d = 1'b1;
                        state_d       = ST_END;
                    end else begin
                        state_d = ST_RELOAD;
                    end
                end else if (live_escaped) begin
                    timer_start_d = 1'b1;
                    state_d       = ST_END;
                end else if (!sprite_torpedo_within_screen) begin
                    if (shots_left_q == '0) begin
                        timer_start_d = 1'b1;
                        state_d       = ST_END;
                    end else begin
                        state_d = ST_RELOAD;
                    end
                end
            end

            ST_RELOAD: begin
                torp_write_xy_d = 1'b1;
                tgt_enable_d    = live_now;
                state_d         = ST_AIM;
            end

            ST_END: begin
                // The timer reports busy only a cycle after its start
                // pulse, so its status is not trusted on the first cycle.
                if (!entered_q && !end_of_game_timer_running) begin
                    state_d = ST_START;
                end
            end

            default: begin
                state_d = ST_START;
            end
        endcase

        entered_d = (state_d != state_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_START;
            entered_q        <= 1'b1;
            tgt_write_xy_q   <= '0;
            tgt_write_dxy_q  <= '0;
            tgt_enable_q     <= '0;
            torp_write_xy_q  <= 1'b0;
            torp_write_dxy_q <= 1'b0;
            torp_enable_q    <= 1'b0;
            timer_start_q    <= 1'b0;
            game_won_q       <= 1'b0;
            shots_left_q     <= '0;
        end else begin
            state_q          <= state_d;
            entered_q        <= entered_d;
            tgt_write_xy_q   <= tgt_write_xy_d;
            tgt_write_dxy_q  <= tgt_write_dxy_d;
            tgt_enable_q     <= tgt_enable_d;
            torp_write_xy_q  <= torp_write_xy_d;
            torp_write_dxy_q <= torp_write_dxy_d;
            torp_enable_q    <= torp_enable_d;
            timer_start_q    <= timer_start_d;
            game_won_q       <= game_won_d;
            shots_left_q     <= shots_left_d;
        end
    end

    assign sprite_target_write_xy       = tgt_write_xy_q;
    assign sprite_target_write_dxy      = tgt_write_dxy_q;
    assign sprite_target_enable_update  = tgt_enable_q;
    assign sprite_torpedo_write_xy      = torp_write_xy_q;
    assign sprite_torpedo_write_dxy     = torp_write_dxy_q;
    assign sprite_torpedo_enable_update = torp_enable_q;
    assign end_of_game_timer_start      = timer_start_q;
    assign game_won                     = game_won_q;
    assign hit_mask                     = trk_hit_mask;
    assign shots_left                   = shots_left_q;

endmodule

// File: doc/game_master_fsm_multi.md
Name: game_master_fsm_multi

Overview:
- Parametrised successor of the single-target game master.
- Sequences one torpedo against N_TARGETS independently moving targets with a limited shot budget.
- Tracks which targets are hit and keeps a saturating score.
- Drives sprite write/update strobes and the end-of-game timer; sits between the sprite engines, collision detectors and the display/timer logic.

Parameters:
N_TARGETS, 2, number of target sprites (1..8)
N_SHOTS, 3, torpedo launches allowed per game (1..15)
SCORE_WIDTH, 8, score counter width; score saturates at all-ones
SHOT_WIDTH, 4, width of shots_left; must hold N_SHOTS

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
key  in  1  fire request, level, already synchronised
sprite_target_write_xy  out  N_TARGETS  per-target load-start-position strobe
sprite_target_write_dxy  out  N_TARGETS  per-target load-velocity strobe
sprite_target_enable_update  out  N_TARGETS  per-target motion enable
sprite_torpedo_write_xy  out  1  load torpedo start position
sprite_torpedo_write_dxy  out  1  load torpedo launch velocity
sprite_torpedo_enable_update  out  1  torpedo motion enable
sprite_target_within_screen  in  N_TARGETS  per-target on-screen flag
sprite_torpedo_within_screen  in  1  torpedo on-screen flag
collision  in  N_TARGETS  torpedo/target[i] overlap
end_of_game_timer_start  out  1  one-cycle timer start pulse
end_of_game_timer_running  in  1  timer busy
game_won  out  1  all targets hit in current/last game
hit_mask  out  N_TARGETS  targets hit this game
shots_left  out  SHOT_WIDTH  remaining launches
score  out  SCORE_WIDTH  cumulative hits since reset

Behaviour:
- All outputs registered: next-state logic decides in cycle t, outputs visible at t+1.
- Reset (asynchronous, any time, including mid-game):
  - state=START; every strobe/enable=0; game_won=0; hit_mask=0; shots_left=0; score=0.
- "live" = target not set in hit_mask.
- START (1 cycle):
  - write_xy pulse for all targets and torpedo; write_dxy pulse for all targets.
  - hit_mask<=0, game_won<=0, shots_left<=N_SHOTS; score is kept. ->AIM.
- AIM:
  - enable_update=1 for live targets only.
  - Priority 1: any live target !within_screen -> lose: timer_start pulse, ->END.
  - Priority 2: key && shots_left!=0 -> shots_left-1, ->SHOOT.
  - key with shots_left==0 is ignored.
- SHOOT:
  - torpedo_write_dxy pulses on the first SHOOT cycle only.
  - torpedo_enable_update=1; live targets enabled; key ignored.
  - Each cycle, newly_hit = collision & ~hit_mask; collisions on already-hit targets are ignored.
  - If newly_hit!=0: hit_mask|=newly_hit; score += popcount(newly_hit), saturating.
    - If hit_mask becomes all-ones: game_won<=1, timer_start pulse, ->END.
    - Otherwise ->RELOAD.
  - Else if any live target !within_screen: timer_start, ->END (lose).
  - Else if torpedo !within_screen: shots_left==0 -> timer_start, ->END (lose); otherwise ->RELOAD.
  - Hit takes priority over exit in the same cycle.
- RELOAD (1 cycle): torpedo_write_xy pulse, live targets stay enabled, ->AIM.
- END:
  - All enables=0.
  - end_of_game_timer_running is ignored in the first END cycle, covering the timer's start latency.
  - Afterwards, !running ->START.
- timer_start is high for exactly one cycle per game.
- game_won holds through END until the next START.

Decomposition:
- Package game_master_pkg: state enum (START, AIM, SHOOT, RELOAD, END; 3 bits) and default parameter constants.
- Sub-module game_hit_tracker: owns hit_mask, the newly_hit computation, popcount and the saturating score. Interface: clear, update_en, collision, hit_mask, all_hit, any_new.

Test Plan (N_TARGETS=2, N_SHOTS=3, SCORE_WIDTH=8):
- Reset release, timer idle -> START strobes on targets 2'b11 and torpedo for one cycle; shots_left=3; AIM enables 2'b11.
- key in AIM, then collision=2'b01 -> hit_mask=01, score=1, RELOAD torpedo_write_xy pulse; AIM enables 2'b10; shots_left=2.
- Second shot with collision=2'b10 -> hit_mask=11, game_won=1, one timer_start pulse; hold running=1 for 10 cycles -> stays END; drop -> START clears game_won, score stays 2.
- Three misses (torpedo exits each time) -> shots_left 3->2->1->0; third exit causes END with game_won=0; key in later AIM is ignored.
- collision=2'b11 in one cycle -> score +2, game_won=1. Score preset at 255 -> saturates at 255.
- Assert reset mid-SHOOT -> all outputs 0 immediately; on release, START sequence repeats.
